// File: rtl/wb_sram_target_pkg.sv
// rtl/wb_sram_target_pkg.sv - shared types and burst address helper for the WB SRAM target
package wb_sram_target_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_END     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2
  } state_e;

  // Computed at 64 bits; the caller truncates, which gives the modulo-2^AW linear wrap.
  function automatic logic [63:0] wb_next_addr(input logic [63:0] addr, input cti_e cti,
                                               input bte_e bte, input int unsigned bytes);
    logic [63:0] step;
    logic [63:0] span;
    logic [63:0] mask;
    step = 64'(bytes);
    case (bte)
      BTE_WRAP4:  span = 64'(bytes) << 2;
      BTE_WRAP8:  span = 64'(bytes) << 3;
      BTE_WRAP16: span = 64'(bytes) << 4;
      default:    span = '0;
    endcase
    mask = span - 64'd1;
    if (cti == CTI_CONST) return addr;
    if (span == 64'd0) return addr + step;
    return (addr & ~mask) | ((addr + step) & mask);
  endfunction

endpackage

// File: rtl/wb_sram_target_ram.sv
// rtl/wb_sram_target_ram.sv - single-port byte-writable SRAM with combinational read
module wb_sram_target_ram #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTES-1:0]      sel,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (sel[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/wb_sram_target.sv
// rtl/wb_sram_target.sv - Wishbone B4 slave fronting a byte-writable SRAM, classic and burst cycles
module wb_sram_target
  import wb_sram_target_pkg::*;
#(
  parameter int                         WB_ADDR_WIDTH = 32,
  parameter int                         WB_DATA_WIDTH = 32,
  parameter int                         DEPTH         = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0]   BASE          = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic                       WE,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  output logic                       ACK,
  output logic                       ERR
);

  localparam int BYTES     = WB_DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(BYTES);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int RANGE_LSB = OFF_W + IDX_W;

  state_e                     state;
  logic                       ack_r;
  logic [WB_ADDR_WIDTH-1:0]   wc;
  logic [WB_ADDR_WIDTH-1:0]   wc_next;
  logic [WB_ADDR_WIDTH-1:0]   adr_al;
  logic [WB_ADDR_WIDTH-1:0]   rd_addr;
  logic [WB_DATA_WIDTH-1:0]   ram_rdata;
  logic [WB_DATA_WIDTH-1:0]   rd_fill;
  logic [IDX_W-1:0]           ram_idx;
  logic                       beat;
  logic                       oor;
  logic                       wr_en;

  function automatic logic oor_of(input logic [WB_ADDR_WIDTH-1:0] a);
    return a[WB_ADDR_WIDTH-1:RANGE_LSB] != BASE[WB_ADDR_WIDTH-1:RANGE_LSB];
  endfunction

  assign adr_al  = ADR & ~WB_ADDR_WIDTH'(BYTES - 1);
  assign wc_next = WB_ADDR_WIDTH'(wb_next_addr(64'(wc), cti_e'(CTI), bte_e'(BTE), BYTES));

  assign beat  = ack_r & CYC & STB;
  assign oor   = oor_of(wc);
  assign ACK   = beat & ~oor;
  assign ERR   = beat & oor;
  assign wr_en = ACK & WE;

  // One port: a write beat owns the index; otherwise it points at the next word to prefetch.
  assign rd_addr = (state == IDLE) ? adr_al : wc_next;
  assign ram_idx = wr_en ? wc[OFF_W +: IDX_W] : rd_addr[OFF_W +: IDX_W];
  assign rd_fill = oor_of(rd_addr) ? '0 : ram_rdata;

  wb_sram_target_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (WB_DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .sel   (SEL),
    .idx   (ram_idx),
    .wdata (DAT_W),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      ack_r <= 1'b0;
      DAT_R <= '0;
      wc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CYC && STB) begin
            wc    <= adr_al;
            DAT_R <= rd_fill;
            ack_r <= 1'b1;
            state <= (CTI == CTI_CONST || CTI == CTI_INCR) ? BURST : SINGLE;
          end
        end
        SINGLE: begin
          ack_r <= 1'b0;
          state <= IDLE;
        end
        BURST: begin
          if (!CYC) begin
            ack_r <= 1'b0;
            state <= IDLE;
          end else if (beat) begin
            if (CTI == CTI_END) begin
              ack_r <= 1'b0;
              state <= IDLE;
            end else begin
              wc    <= wc_next;
              DAT_R <= rd_fill;
            end
          end
        end
        default: begin
          ack_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_target.sv
// tb/tb_wb_sram_target.sv - randomized self-checking bench for wb_sram_target against a word-array model
module tb_wb_sram_target;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_r;
    logic        ack, err;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [1024];

    always #5 clk = ~clk;

    wb_sram_target #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .DEPTH         (1024),
        .BASE          (32'h0)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .ADR   (adr),
        .DAT_W (dat_w),
        .SEL   (sel),
        .CYC   (cyc),
        .STB   (stb),
        .WE    (we),
        .CTI   (cti),
        .BTE   (bte),
        .DAT_R (dat_r),
        .ACK   (ack),
        .ERR   (err)
    );

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] c,
                                              input logic [1:0] b, input int k);
        logic [31:0] span;
        if (c == 3'b001) return a;
        if (b == 2'b00) return a + 32'(4 * k);
        span = 32'd8 << b;
        return (a & ~(span - 32'd1)) | ((a + 32'(4 * k)) % span);
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return a < 32'h1000;
    endfunction

    function automatic logic [31:0] expect_rd(input logic [31:0] a);
        return in_range(a) ? model[a[11:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s);
        @(negedge clk);
        cyc = 1; stb = 1; adr = a; we = w; cti = 3'b000; bte = 2'b00; dat_w = d; sel = s;
        #1;
        checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL classic_wait a=%h got ack=%b err=%b want 0 0", a, ack, err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ack !== in_range(a) || err !== !in_range(a)) begin
            failures++;
            $display("FAIL classic_term a=%h got ack=%b err=%b want ack=%b", a, ack, err, in_range(a));
        end
        if (!w) begin
            checks++;
            if (dat_r !== expect_rd(a)) begin
                failures++;
                $display("FAIL classic_rd a=%h got %h want %h", a, dat_r, expect_rd(a));
            end
        end else if (in_range(a)) begin
            model[a[11:2]] = merge(model[a[11:2]], d, s);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cyc = 0; stb = 0; cti = 3'b000;
        #1;
        checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL idle_low got ack=%b err=%b want 0 0", ack, err);
        end
    endtask

    task automatic burst(input logic [31:0] a, input logic w, input logic [2:0] c,
                         input logic [1:0] b, input int n, input int gap_after, input int gap_len,
                         input logic rnd_sel, input int abort_at, input int rst_at);
        logic [31:0] ba, d;
        logic [3:0]  s;
        @(negedge clk);
        cyc = 1; stb = 1; adr = a; we = w; cti = c; bte = b; sel = 4'hF; dat_w = $urandom;
        #1;
        checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL burst_wait a=%h got ack=%b err=%b want 0 0", a, ack, err);
        end
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                @(negedge clk);
                cyc = 0; stb = 0; cti = 3'b000;
                #1;
                checks++;
                if (ack !== 1'b0 || err !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_low got ack=%b err=%b want 0 0", ack, err);
                end
                return;
            end
            if (k == rst_at) begin
                @(negedge clk);
                rstn = 0;
                @(negedge clk);
                #1;
                checks++;
                if (ack !== 1'b0 || err !== 1'b0 || dat_r !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_mid got ack=%b err=%b dat_r=%h want 0 0 0", ack, err, dat_r);
                end
                rstn = 1; cyc = 0; stb = 0; cti = 3'b000;
                return;
            end
            @(negedge clk);
            ba = beat_addr(a, c, b, k);
            s = rnd_sel ? 4'($urandom_range(15, 0)) : 4'hF;
            d = $urandom;
            adr = ba; stb = 1; cti = (k == n - 1) ? 3'b111 : c; sel = s; dat_w = d;
            #1;
            checks++;
            if (ack !== in_range(ba) || err !== !in_range(ba)) begin
                failures++;
                $display("FAIL burst_beat k=%0d a=%h got ack=%b err=%b want ack=%b", k, ba, ack, err,
                         in_range(ba));
            end
            if (!w) begin
                checks++;
                if (dat_r !== expect_rd(ba)) begin
                    failures++;
                    $display("FAIL burst_rd k=%0d a=%h got %h want %h", k, ba, dat_r, expect_rd(ba));
                end
            end else if (in_range(ba)) begin
                model[ba[11:2]] = merge(model[ba[11:2]], d, s);
            end
            if (k == gap_after && k != n - 1) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    stb = 0;
                    #1;
                    checks++;
                    if (ack !== 1'b0 || err !== 1'b0) begin
                        failures++;
                        $display("FAIL gap_low k=%0d got ack=%b err=%b want 0 0", k, ack, err);
                    end
                    if (!w) begin
                        checks++;
                        if (dat_r !== expect_rd(beat_addr(a, c, b, k + 1))) begin
                            failures++;
                            $display("FAIL gap_hold k=%0d got %h want %h", k, dat_r,
                                     expect_rd(beat_addr(a, c, b, k + 1)));
                        end
                    end
                end
            end
        end
        idle_cycle();
    endtask

    task automatic test_reset();
        rstn = 0; cyc = 0; stb = 0; we = 0; adr = 0; dat_w = 0; sel = 0; cti = 0; bte = 0;
        repeat (3) @(negedge clk);
        cyc = 1; stb = 1;
        @(negedge clk);
        #1;
        checks++;
        if (ack !== 1'b0 || err !== 1'b0 || dat_r !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got ack=%b err=%b dat_r=%h want 0 0 0", ack, err, dat_r);
        end
        cyc = 0; stb = 0; rstn = 1;
    endtask

    task automatic test_fill();
        burst(32'h0, 1'b1, 3'b010, 2'b00, 1024, -1, 0, 1'b0, -1, -1);
    endtask

    task automatic test_classic();
        classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
        idle_cycle();
        classic(32'h10, 1'b0, 32'h0, 4'hF);
        checks++;
        if (dat_r !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL classic_value got %h want deadbeef", dat_r);
        end
        idle_cycle();
    endtask

    task automatic test_byte_lanes();
        classic(32'h20, 1'b1, 32'h11223344, 4'hF);
        idle_cycle();
        classic(32'h20, 1'b1, 32'hAABBCCDD, 4'b0101);
        idle_cycle();
        classic(32'h20, 1'b0, 32'h0, 4'hF);
        checks++;
        if (dat_r !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL byte_lanes got %h want 11bb33dd", dat_r);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        classic(32'h10, 1'b0, 32'h0, 4'hF);
        classic(32'h20, 1'b0, 32'h0, 4'hF);
        classic(32'h24, 1'b1, $urandom, 4'hF);
        idle_cycle();
    endtask

    task automatic test_wrap4();
        burst(32'h08, 1'b0, 3'b010, 2'b01, 4, -1, 0, 1'b0, -1, -1);
    endtask

    task automatic test_gap();
        burst(32'h40, 1'b1, 3'b010, 2'b00, 8, 2, 2, 1'b0, -1, -1);
        burst(32'h40, 1'b0, 3'b010, 2'b00, 8, 2, 2, 1'b0, -1, -1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [2:0]  c;
        int n;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 4) == 0) ? 32'h1000 - 32'(4 * $urandom_range(1, 6))
                                            : 32'($urandom_range(0, 1023)) << 2;
            c = ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b010;
            n = $urandom_range(2, 12);
            burst(a, 1'($urandom_range(0, 1)), c, 2'($urandom_range(0, 3)), n,
                  $urandom_range(0, n), $urandom_range(1, 3), 1'b1, -1, -1);
        end
    endtask

    task automatic test_decode();
        classic(32'h1000, 1'b0, 32'h0, 4'hF);
        idle_cycle();
        classic(32'h1000, 1'b1, 32'h5A5A5A5A, 4'hF);
        idle_cycle();
        burst(32'hFFC, 1'b0, 3'b010, 2'b00, 2, -1, 0, 1'b0, -1, -1);
        burst(32'hFFC, 1'b1, 3'b010, 2'b00, 3, -1, 0, 1'b0, -1, -1);
        classic(32'h0, 1'b0, 32'h0, 4'hF);
        idle_cycle();
        classic(32'h4, 1'b0, 32'h0, 4'hF);
        idle_cycle();
    endtask

    task automatic test_abort();
        burst(32'h100, 1'b0, 3'b010, 2'b00, 6, -1, 0, 1'b0, 2, -1);
        classic(32'h100, 1'b0, 32'h0, 4'hF);
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        burst(32'h200, 1'b0, 3'b010, 2'b00, 6, -1, 0, 1'b0, -1, 2);
        for (int i = 0; i < 6; i++) begin
            classic(32'($urandom_range(0, 1023)) << 2, 1'b0, 32'h0, 4'hF);
            idle_cycle();
        end
        classic(32'h10, 1'b0, 32'h0, 4'hF);
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_classic();
        test_byte_lanes();
        test_back_to_back();
        test_wrap4();
        test_gap();
        test_random();
        test_decode();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
